arp_cam_lookup: RTL

//  Parametrised ARP cache for the router output-port-lookup pipeline: maps next-hop IPv4 to dest MAC.

---
 rtl/arp_cam_pkg.sv | 18 +
 rtl/arp_prio_enc.sv | 24 ++
 rtl/arp_cam_lookup.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/arp_cam_pkg.sv
// Entry layout shared by the ARP CAM and its host port.
// An entry is an 81-bit {valid, mac, ip} word.
package arp_cam_pkg;

    localparam int ENTRY_W   = 81;
    localparam int VALID_BIT = 80;
    localparam int MAC_MSB   = 79;
    localparam int MAC_LSB   = 32;
    localparam int IP_MSB    = 31;
    localparam int IP_LSB    = 0;

    typedef struct packed {
        logic        valid;
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_entry_t;

endpackage

// File: rtl/arp_prio_enc.sv
// Lowest-index priority encoder for the ARP CAM match vector.
// It is purely combinational; index is 0 when nothing matches.
module arp_prio_enc #(
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  match,
    output logic              any,
    output logic [ADDR_W-1:0] index
);

    // NOTE: index is given a default before the loop, so it is assigned on
    // every path and no latch is inferred. The loop uses blocking '=' so a
    // later, lower-index hit overrides an earlier, higher-index one.
    always_comb begin
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) index = ADDR_W'(i);
        end
    end

    assign any = |match;

endmodule

// File: rtl/arp_cam_lookup.sv
// ARP cache: next-hop IPv4 -> MAC through a 2-stage lookup pipeline, with a
// host table port and hit/miss counters.
// Define ARP_AGING_EN to add per-entry age counters driven by age_tick.
module arp_cam_lookup
    import arp_cam_pkg::*;
#(
    parameter  int DEPTH  = 32,
    parameter  int TAG_W  = 32,
    parameter  int AGE_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               AXI_ACLK,
    input  logic               AXI_RESETN,
    input  logic               lkp_req_valid,
    output logic               lkp_req_ready,
    input  logic [31:0]        lkp_req_ip,
    input  logic [TAG_W-1:0]   lkp_req_tag,
    output logic               lkp_rsp_valid,
    input  logic               lkp_rsp_ready,
    output logic               lkp_rsp_hit,
    output logic [47:0]        lkp_rsp_mac,
    output logic [ADDR_W-1:0]  lkp_rsp_index,
    output logic [TAG_W-1:0]   lkp_rsp_tag,
    input  logic               tbl_wr_req,
    input  logic [ADDR_W-1:0]  tbl_wr_addr,
    input  logic [ENTRY_W-1:0] tbl_wr_data,
    output logic               tbl_wr_ack,
    input  logic               tbl_rd_req,
    input  logic [ADDR_W-1:0]  tbl_rd_addr,
    output logic [ENTRY_W-1:0] tbl_rd_data,
    output logic               tbl_rd_ack,
    input  logic               tbl_clear,
    input  logic               age_tick,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
);

    arp_entry_t        tbl_q [DEPTH];
    arp_entry_t        wr_entry;
    logic [DEPTH-1:0]  match;
    logic              match_any;
    logic [ADDR_W-1:0] match_idx;
    logic [DEPTH-1:0]  expired;

    logic              s1_valid;
    logic              s1_hit;
    logic [47:0]       s1_mac;
    logic [ADDR_W-1:0] s1_index;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_stall;
    logic              rsp_hs;

    assign wr_entry = '{valid: tbl_wr_data[VALID_BIT],
                        mac:   tbl_wr_data[MAC_MSB:MAC_LSB],
                        ip:    tbl_wr_data[IP_MSB:IP_LSB]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = tbl_q[i].valid && (tbl_q[i].ip == lkp_req_ip);
        end
    end

    arp_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
        .match (match),
        .any   (match_any),
        .index (match_idx)
    );

    assign s2_stall      = lkp_rsp_valid && !lkp_rsp_ready;
    assign lkp_req_ready = !(s1_valid && s2_stall);
    assign rsp_hs        = lkp_rsp_valid && lkp_rsp_ready;

    // The lookup result is snapshotted when the request is accepted, so a
    // host write landing while the request is in flight never alters it.
    // NOTE: all sequential state is updated with non-blocking '<='. Every
    // flop then samples values from before the clock edge.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_mac   <= '0;
            s1_index <= '0;
            s1_tag   <= '0;
        end else if (lkp_req_ready) begin
            s1_valid <= lkp_req_valid;
            if (lkp_req_valid) begin
                s1_hit   <= match_any;
                s1_mac   <= match_any ? tbl_q[match_idx].mac : '0;
                s1_index <= match_idx;
                s1_tag   <= lkp_req_tag;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            lkp_rsp_valid <= 1'b0;
            lkp_rsp_hit   <= 1'b0;
            lkp_rsp_mac   <= '0;
            lkp_rsp_index <= '0;
            lkp_rsp_tag   <= '0;
        end else if (!s2_stall) begin
            lkp_rsp_valid <= s1_valid;
            if (s1_valid) begin
                lkp_rsp_hit   <= s1_hit;
                lkp_rsp_mac   <= s1_mac;
                lkp_rsp_index <= s1_index;
                lkp_rsp_tag   <= s1_tag;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rsp_hs) begin
            if (lkp_rsp_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            tbl_wr_ack  <= 1'b0;
            tbl_rd_ack  <= 1'b0;
            tbl_rd_data <= '0;
        end else begin
            tbl_wr_ack <= tbl_wr_req;
            tbl_rd_ack <= tbl_rd_req;
            if (tbl_rd_req) tbl_rd_data <= tbl_q[tbl_rd_addr];
        end
    end

    // Priority for each entry: clear, then host write, then age expiry.
    // NOTE: the table is a flop array with a defined power-up state, so it
    // takes the async reset. A RAM-based table could not be reset this way.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tbl_clear) begin
                    tbl_q[i].valid <= 1'b0;
                end else if (tbl_wr_req && (tbl_wr_addr == ADDR_W'(i))) begin
                    tbl_q[i] <= wr_entry;
                end else if (expired[i]) begin
                    tbl_q[i].valid <= 1'b0;
                end
            end
        end
    end

`ifdef ARP_AGING_EN
    logic [AGE_W-1:0] age_q [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            expired[i] = tbl_q[i].valid && (age_q[i] == {AGE_W{1'b1}});
        end
    end

    // A hit handshake restarts aging and takes precedence over a coincident tick.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tbl_clear
                    || (tbl_wr_req && (tbl_wr_addr == ADDR_W'(i)))
                    || (rsp_hs && lkp_rsp_hit && (lkp_rsp_index == ADDR_W'(i)))) begin
                    age_q[i] <= '0;
                end else if (age_tick && tbl_q[i].valid && !expired[i]) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end
`else
    logic unused_aging;

    assign expired      = '0;
    assign unused_aging = age_tick ^ (AGE_W > 0);
`endif

endmodule
